spi_master_multi: RTL

- Parametrised full-duplex SPI master for N-bit words and NUM_SLAVES chip selects. Successor to the fixed 8-bit, 3-slave master/slave pair.
- Adds per-transfer selection of CPOL/CPHA mode, a programmable SCLK divider, optional LSB-first ordering, a valid/ready start handshake and invalid-slave error reporting.
- Sits between the system controller and the off-block SPI pins (sclk, mosi, miso, cs_n).

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 53 +++++
 rtl/spi_master_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the multi-slave SPI master.
//   spi_state_e : controller states
//   MODE0..3    : SPI mode encodings as {cpol, cpha}
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        XFER   = 3'd2,
        HOLD   = 3'd3,
        REJECT = 3'd4
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: down-counter producing one strobe per CLK_DIV-cycle
// half-period, plus the SCLK phase register.
// Ports:
//   clk, rst    : system clock, synchronous active-low reset
//   en          : run the half-period counter (reloads while low)
//   toggle      : let SCLK toggle at the end of each half-period
//   cpol        : idle level of SCLK
//   half_tick   : last cycle of a half-period
//   lead_edge   : half_tick where SCLK is about to leave its idle level
//   trail_edge  : half_tick where SCLK is about to return to its idle level
//   sclk        : SPI clock output
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle,
    input  logic cpol,
    output logic half_tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;   // 1 while SCLK is away from its idle level

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt   <= CNT_LOAD;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= CNT_LOAD;
            if (toggle) begin
                phase <= ~phase;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign half_tick  = en && (cnt == '0);
    assign lead_edge  = half_tick && toggle && !phase;
    assign trail_edge = half_tick && toggle && phase;
    // Polarity is applied after the phase flop so SCLK follows a newly
    // latched cpol immediately, and idles at the last transfer's cpol.
    assign sclk       = phase ^ cpol;

endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master, N-bit words, NUM_SLAVES chip selects, per-transfer
// CPOL/CPHA, optional LSB-first order, valid/ready start handshake.
// Ports:
//   clk, rst              : system clock, synchronous active-low reset
//   start / ready         : request handshake, accepted when both high
//   slave_sel, cpol, cpha,
//   lsb_first, data_in    : transfer parameters, latched on accept
//   data_out              : received word, updated on successful completion
//   done, err             : completion pulse; err marks a rejected slave index
//   busy                  : any state except IDLE
//   sclk, mosi, miso, cs_n: SPI pins
//
// state  | meaning
// IDLE   | waiting for start; sclk at last cpol, all cs_n high
// SETUP  | cs_n low, first bit on mosi, one half-period
// XFER   | 2N half-periods, sclk toggling
// HOLD   | sclk idle, cs_n still low, one half-period
// REJECT | slave index out of range; done+err this cycle
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int N          = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 2,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [N-1:0]          data_in,
    output logic [N-1:0]          data_out,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] cs_n
);

    localparam int HC_W = $clog2(2 * N);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * N - 1);
    localparam logic [SEL_W:0]  SEL_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

    spi_state_e       state, state_d;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       mode_q;
    logic             lsb_q;
    logic [N-1:0]     tx_sr;
    logic [N-1:0]     rx_sr;
    logic [N-1:0]     rx_ord;
    logic [N-1:0]     data_out_q;
    logic [HC_W-1:0]  half_cnt;
    logic             done_q;

    logic sel_ok, accept, active, late_phase;
    logic half_tick, lead_edge, trail_edge;
    logic first_half, last_half, shift_en, sample_en;

    assign sel_ok     = {1'b0, slave_sel} < SEL_LIMIT;
    assign accept     = (state == IDLE) && start;
    assign active     = (state == SETUP) || (state == XFER) || (state == HOLD);
    assign late_phase = (mode_q == MODE1) || (mode_q == MODE3);
    assign first_half = (half_cnt == HC_LAST);
    assign last_half  = (half_cnt == '0);

    // cpha=0: data launched before the first edge, sampled on leading edges.
    // cpha=1: first bit already on the line, so the first leading edge
    // must not shift; samples move to trailing edges.
    assign shift_en  = late_phase ? (lead_edge && !first_half)
                                  : (trail_edge && !last_half);
    assign sample_en = late_phase ? trail_edge : lead_edge;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (active),
        .toggle     (state == XFER),
        .cpol       (mode_q[1]),
        .half_tick  (half_tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .sclk       (sclk)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = sel_ok ? SETUP : REJECT;
            SETUP:   if (half_tick) state_d = XFER;
            XFER:    if (half_tick && last_half) state_d = HOLD;
            HOLD:    if (half_tick) state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            mode_q     <= MODE0;
            lsb_q      <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            half_cnt   <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= (state == HOLD) && half_tick;
            if (accept && sel_ok) begin
                sel_q    <= slave_sel;
                mode_q   <= {cpol, cpha};
                lsb_q    <= lsb_first;
                tx_sr    <= data_in;
                rx_sr    <= '0;
                half_cnt <= HC_LAST;
            end
            if ((state == XFER) && half_tick) begin
                half_cnt <= half_cnt - HC_W'(1);
            end
            if (shift_en) begin
                tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (sample_en) begin
                rx_sr <= {rx_sr[N-2:0], miso};
            end
            if ((state == HOLD) && half_tick) begin
                data_out_q <= rx_ord;
            end
        end
    end

    // rx_sr holds bits in arrival order (first arrival at the MSB); for
    // LSB-first transfers that order is reversed into word order.
    always_comb begin
        rx_ord = rx_sr;
        for (int i = 0; i < N; i++) begin
            rx_ord[i] = lsb_q ? rx_sr[N-1-i] : rx_sr[i];
        end
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (active && (sel_q == SEL_W'(i))) begin
                cs_n[i] = 1'b0;
            end
        end
    end

    assign mosi     = active ? (lsb_q ? tx_sr[0] : tx_sr[N-1]) : 1'b0;
    assign ready    = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = done_q || (state == REJECT);
    assign err      = (state == REJECT);
    assign data_out = data_out_q;

endmodule
